// File: rtl/led_pkg.sv
// Shared types and defaults for the LED1 blink arbiter.
package led_pkg;

    typedef enum logic [2:0] {IDLE, ON, OFF, GAP, FIN} state_t;

    localparam int CLK_HZ       = 32000000;
    localparam int TICK_DIV_DEF = CLK_HZ / 2;
    localparam int BLINK_W_DEF  = 4;

endpackage

// File: rtl/led_phase_timer.sv
// Loadable phase down-counter; expires when the count sits at zero.
module led_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             exp_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exp_o = (cnt_q == '0);

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing LED1 between requesters; each grant plays a
// burst of equal on/off phases followed by a dark gap.
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int BLINK_W  = BLINK_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*BLINK_W-1:0] COUNT,
    output logic [N_REQ-1:0]         GNT,
    output logic [N_REQ-1:0]         DONE,
    output logic                     BUSY,
    output logic                     LED1
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TW    = $clog2(2 * TICK_DIV);
    localparam logic [TW-1:0] PH_LOAD  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(2 * TICK_DIV - 1);
    localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BLINK_W-1:0] rem_q, rem_d;
    logic               abort_q, abort_d;
    logic               led_q;
    logic [IDX_W-1:0]   pick;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_exp;

    // Rotate so the search starts just after the last winner, take the
    // lowest set bit, then rotate the index back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        int                 start;
        int                 sel;
        start = (int'(ptr) + 1) % N_REQ;
        dbl   = {req, req} >> start;
        rot   = dbl[N_REQ-1:0];
        sel   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) sel = k;
        end
        sel = (sel + start) % N_REQ;
        return IDX_W'(sel);
    endfunction

    assign pick = rr_pick(REQ, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    ptr_d   = pick;
                    gnt_d   = ONE << pick;
                    rem_d   = COUNT[int'(pick)*BLINK_W +: BLINK_W];
                    abort_d = 1'b0;
                    if (rem_d != '0) begin
                        state_d = ON;
                    end else begin
                        state_d = FIN;
                        done_d  = ONE << pick;
                    end
                end
            end
            ON: begin
                if (!REQ[ptr_q]) begin
                    state_d = GAP;
                    abort_d = 1'b1;
                end else if (tmr_exp) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (!REQ[ptr_q]) begin
                    state_d = GAP;
                    abort_d = 1'b1;
                end else if (tmr_exp) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_d != '0) ? ON : GAP;
                end
            end
            GAP: begin
                // An aborted burst releases straight to IDLE so no DONE is seen.
                if (tmr_exp) begin
                    if (abort_q) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end else begin
                        state_d = FIN;
                        done_d  = gnt_q;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            ON, OFF: tmr_val = PH_LOAD;
            GAP:     tmr_val = GAP_LOAD;
            default: tmr_val = '0;
        endcase
    end

    led_phase_timer #(
        .CNT_W(TW)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .exp_o      (tmr_exp)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            abort_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            abort_q <= abort_d;
            led_q   <= (state_d == ON);
        end
    end

    always_ff @(posedge CLK) begin
        rem_q <= rem_d;
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign BUSY = (state_q != IDLE);
    assign LED1 = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed self-checking bench for led_blink_arbiter with TICK_DIV=4.
module tb_led_blink_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [15:0] COUNT;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic        BUSY;
    logic        LED1;

    int n_cmp = 0;
    int n_bad = 0;

    led_blink_arbiter #(
        .N_REQ    (4),
        .TICK_DIV (4),
        .BLINK_W  (4)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .COUNT (COUNT),
        .GNT   (GNT),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .LED1  (LED1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        RST = 1'b1; REQ = 4'b0000; COUNT = 16'h0000;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", GNT); end
        n_cmp++; if (DONE !== 4'b0000) begin n_bad++; $display("FAIL reset_done got %b want 0000", DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL reset_led got %b want 0", LED1); end
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", BUSY); end
    endtask

    task automatic test_single();
        logic exp_led;
        REQ = 4'b0001; COUNT = 16'h0002;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            exp_led = (i < 16) && (((i / 4) % 2) == 0);
            n_cmp++; if (LED1 !== exp_led) begin n_bad++; $display("FAIL single_led cyc %0d got %b want %b", i, LED1, exp_led); end
            n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL single_gnt cyc %0d got %b want 0001", i, GNT); end
            n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy cyc %0d got %b want 1", i, BUSY); end
            n_cmp++; if (DONE !== ((i == 24) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL single_done cyc %0d got %b", i, DONE); end
            if (i == 24) REQ = 4'b0000;
        end
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL single_end_gnt got %b want 0000", GNT); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL single_end_busy got %b want 0", BUSY); end
    endtask

    task automatic test_contention();
        logic [3:0] order [4];
        logic [3:0] prev;
        int ng, nd, idle_run;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;
        RST = 1'b1; REQ = 4'b0000;
        @(negedge CLK);
        RST = 1'b0; REQ = 4'b1011; COUNT = 16'h1111;
        prev = 4'b0000; ng = 0; nd = 0; idle_run = 0;
        for (int c = 0; c < 300 && nd < 4; c++) begin
            @(negedge CLK);
            n_cmp++; if ((GNT & (GNT - 4'd1)) !== 4'b0000) begin n_bad++; $display("FAIL cont_onehot got %b", GNT); end
            if (GNT == 4'b0000) begin
                idle_run++;
            end else if (prev == 4'b0000) begin
                n_cmp++; if (GNT !== order[ng]) begin n_bad++; $display("FAIL cont_order grant %0d got %b want %b", ng, GNT, order[ng]); end
                if (ng > 0) begin
                    n_cmp++; if (idle_run != 1) begin n_bad++; $display("FAIL cont_gap grant %0d got %0d want 1", ng, idle_run); end
                end
                ng++;
                idle_run = 0;
            end
            if (DONE != 4'b0000) nd++;
            if (nd == 4) REQ = 4'b0000;
            prev = GNT;
        end
        n_cmp++; if (nd != 4) begin n_bad++; $display("FAIL cont_timeout done pulses got %0d want 4", nd); end
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL cont_end_busy got %b want 0", BUSY); end
    endtask

    task automatic test_zero_count();
        REQ = 4'b0100; COUNT = 16'h1011;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0100) begin n_bad++; $display("FAIL zero_gnt got %b want 0100", GNT); end
        n_cmp++; if (DONE !== 4'b0100) begin n_bad++; $display("FAIL zero_done got %b want 0100", DONE); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b want 1", BUSY); end
        n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL zero_led got %b want 0", LED1); end
        REQ = 4'b0000;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL zero_end_gnt got %b want 0000", GNT); end
        n_cmp++; if (DONE !== 4'b0000) begin n_bad++; $display("FAIL zero_end_done got %b want 0000", DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL zero_end_busy got %b want 0", BUSY); end
    endtask

    task automatic test_abort();
        logic exp_led;
        REQ = 4'b0010; COUNT = 16'h0030;
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            exp_led = (i < 4) || (i == 8) || (i == 9);
            n_cmp++; if (LED1 !== exp_led) begin n_bad++; $display("FAIL abort_led cyc %0d got %b want %b", i, LED1, exp_led); end
            n_cmp++; if (GNT !== ((i < 18) ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL abort_gnt cyc %0d got %b", i, GNT); end
            n_cmp++; if (BUSY !== (i < 18)) begin n_bad++; $display("FAIL abort_busy cyc %0d got %b", i, BUSY); end
            n_cmp++; if (DONE !== 4'b0000) begin n_bad++; $display("FAIL abort_done cyc %0d got %b want 0000", i, DONE); end
            if (i == 9) REQ = 4'b0000;
        end
        REQ = 4'b1111; COUNT = 16'h0000;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0100) begin n_bad++; $display("FAIL abort_next1 got %b want 0100", GNT); end
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL abort_idle got %b want 0000", GNT); end
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b1000) begin n_bad++; $display("FAIL abort_next2 got %b want 1000", GNT); end
        REQ = 4'b0000;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        REQ = 4'b0010; COUNT = 16'h2222;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0010) begin n_bad++; $display("FAIL rstmid_gnt got %b want 0010", GNT); end
        repeat (5) @(negedge CLK);
        n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_off_led got %b want 0", LED1); end
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL rstmid_gnt0 got %b want 0000", GNT); end
        n_cmp++; if (DONE !== 4'b0000) begin n_bad++; $display("FAIL rstmid_done got %b want 0000", DONE); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", BUSY); end
        n_cmp++; if (LED1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_led got %b want 0", LED1); end
        REQ = 4'b1111;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0000) begin n_bad++; $display("FAIL rstmid_held got %b want 0000", GNT); end
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++; if (GNT !== 4'b0001) begin n_bad++; $display("FAIL rstmid_first got %b want 0001", GNT); end
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy1 got %b want 1", BUSY); end
        RST = 1'b1; REQ = 4'b0000;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_max_count();
        int   rises, done_i;
        logic prev_led;
        logic [3:0] done_v;
        REQ = 4'b1000; COUNT = 16'hF000;
        rises = 0; done_i = -1; prev_led = 1'b0; done_v = 4'b0000;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (LED1 && !prev_led) rises++;
            prev_led = LED1;
            if (DONE != 4'b0000) begin
                done_i = i; done_v = DONE; REQ = 4'b0000;
                break;
            end
        end
        n_cmp++; if (rises != 15) begin n_bad++; $display("FAIL max_rises got %0d want 15", rises); end
        n_cmp++; if (done_v !== 4'b1000) begin n_bad++; $display("FAIL max_done got %b want 1000", done_v); end
        n_cmp++; if (done_i != 128) begin n_bad++; $display("FAIL max_done_cyc got %0d want 128", done_i); end
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL max_end_busy got %b want 0", BUSY); end
    endtask

    initial begin
        RST = 1'b1; REQ = 4'b0000; COUNT = 16'h0000;
        test_reset();
        test_single();
        test_contention();
        test_zero_count();
        test_abort();
        test_reset_mid();
        test_max_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the single board status LED (LED1) between up to N_REQ requesters. Each requester asks for a burst of blinks; the block grants one requester at a time in round-robin order, drives LED1 with exact on/off phases derived from CLK, then inserts a dark gap so bursts from different requesters stay distinguishable. It sits at the top level between status-producing logic and the LED1 pin.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- TICK_DIV, 16000000: CLK cycles per LED phase (0.5 s at 32 MHz). Must be at least 2.
- BLINK_W, 4: width of each per-requester blink count.

Ports:
- CLK  in  1  system clock, single clock domain.
- RST  in  1  synchronous reset, active-high.
- REQ  in  N_REQ  per-requester level request. Must be held until DONE, or the burst is aborted.
- COUNT  in  N_REQ*BLINK_W  blink count for requester i in bits [i*BLINK_W +: BLINK_W]. Sampled only at grant.
- GNT  out  N_REQ  one-hot grant, registered.
- DONE  out  N_REQ  one-cycle completion pulse per requester, registered.
- BUSY  out  1  high whenever state is not IDLE.
- LED1  out  1  LED drive, registered.

## Operation
- Reset values: state IDLE, GNT=0, DONE=0, BUSY=0, LED1=0, round-robin pointer PTR=N_REQ-1, so requester 0 has first priority.
- **IDLE**
  - If any REQ bit is high, select the first set bit searching from PTR+1 modulo N_REQ.
  - Set GNT to that bit, set PTR to its index, and latch REM = its COUNT.
  - If COUNT != 0, go to ON.
  - If COUNT == 0, go to FIN (zero-length grant: no LED activity).
- **ON**
  - LED1=1 for TICK_DIV cycles, then go to OFF.
- **OFF**
  - LED1=0 for TICK_DIV cycles, then REM = REM-1.
  - If REM is still nonzero, go to ON; otherwise go to GAP.
- **GAP**
  - LED1=0 for 2*TICK_DIV cycles, then go to FIN.
- **FIN**
  - One cycle. Pulse DONE for the granted index, clear GNT, go to IDLE.
- **Abort**
  - If the granted REQ bit drops in ON or OFF: go to GAP next cycle with LED1=0. No DONE is issued; GNT clears at the end of GAP.
  - If it drops in GAP, ignore it.
- **Arithmetic**
  - Phase counter is a down-counter of width $clog2(2*TICK_DIV), reloaded on every state entry.
  - REM is BLINK_W bits and never wraps, because the state leaves OFF when REM reaches 0.
- **Simultaneous events**
  - REQ changes on non-granted lines during a burst have no effect until IDLE.
  - A requester whose DONE pulses may re-request immediately; round-robin order gives the other pending requesters priority first.
- **Reset mid-operation**
  - RST has priority over everything. Outputs take reset values at the next edge, PTR resets, and no DONE is issued.

## Timing
- REQ high in IDLE at edge k → GNT, BUSY and LED1=1 visible after edge k+1 (1-cycle latency).
- Burst of N blinks: LED1 alternates exactly TICK_DIV high / TICK_DIV low, N times.
- After the last OFF phase: 2*TICK_DIV cycles dark, then one FIN cycle with DONE=1 and GNT still high.
- GNT/BUSY duration: 2*TICK_DIV*(N+1) + 1 cycles. For COUNT=0 the duration is 1 cycle: FIN only, with DONE and GNT together.
- Back-to-back: FIN at cycle t → IDLE at t+1 → next GNT at t+2. The minimum inter-grant gap is therefore 1 IDLE cycle.
- GNT and DONE are never asserted for more than one index at a time.

## Structure
- Package led_pkg holds:
  - state enum {IDLE, ON, OFF, GAP, FIN};
  - constant CLK_HZ = 32000000;
  - defaults TICK_DIV_DEF = CLK_HZ/2 and BLINK_W_DEF = 4.
- Sub-module led_phase_timer: loadable down-counter with LOAD (value) and EXP (expired) outputs; the FSM loads it on each state entry.
- Round-robin selection is a combinational function in the top module (rotate REQ by PTR+1, priority-encode, rotate back).

## Test plan
Simulate with TICK_DIV=4, N_REQ=4, BLINK_W=4.
- **Single request:** RST then REQ=0001, COUNT[0]=2 → GNT=0001 one cycle later; LED1 pattern 1111 0000 1111 0000, then 8 cycles low; DONE[0] pulses once; GNT/BUSY high for 25 cycles.
- **Contention:** REQ=1011 all held, counts 1 → grant order 0, 1, 3, 0; one idle cycle between each FIN and the next GNT; never two GNT bits set.
- **Zero count:** REQ=0100, COUNT[2]=0 → GNT=0100 and DONE[2] in the same single cycle; LED1 stays 0; BUSY high for 1 cycle.
- **Abort:** REQ[1] drops during the second ON phase of a 3-blink burst → LED1=0 next cycle, 8-cycle gap, GNT clears, no DONE; PTR=1, so next order starts at 2.
- **Reset mid-burst:** RST asserted during OFF → after the next edge all outputs 0 and BUSY 0; with REQ=1111 held, requester 0 is granted first after release.
- **Max count:** COUNT=15 → exactly 15 LED1 rising edges, REM does not underflow, then DONE.
